// File: rtl/redundant_accumulator_pkg.sv
//==============================================================================
// Module : redundant_accumulator_pkg
// Desc   : Shared state encoding and default widths for the accumulator and
//          the dot-product array that feeds it.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

package redundant_accumulator_pkg;

   localparam int unsigned DOT_OUT_WIDTH = 20;
   localparam int unsigned ACC_WIDTH_DEF = 32;
   localparam int unsigned CNT_WIDTH_DEF = 16;

   typedef enum logic [0:0] {
      ACCUM = 1'b0,
      HOLD  = 1'b1
   } acc_state_e;

endpackage

`default_nettype wire

// File: rtl/redundant_accumulator_cs_resolve.sv
//==============================================================================
// Module : cs_resolve
// Desc   : Carry-propagate add of a carry-save pair, sign-extended to the
//          accumulator width.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module cs_resolve
   import redundant_accumulator_pkg::*;
#(
   parameter int unsigned IN_WIDTH  = DOT_OUT_WIDTH,
   parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF
) (
   input  logic [IN_WIDTH-1:0]  sum_i,
   input  logic [IN_WIDTH-1:0]  carry_i,
   output logic [ACC_WIDTH-1:0] value_o
);

   logic [IN_WIDTH-1:0] w_raw;

   // Modulo 2^IN_WIDTH add; the result is read as two's complement.
   assign w_raw = sum_i + carry_i;

   if (ACC_WIDTH > IN_WIDTH) begin : g_sign_ext
      assign value_o = {{(ACC_WIDTH - IN_WIDTH){w_raw[IN_WIDTH-1]}}, w_raw};
   end else begin : g_same_width
      assign value_o = w_raw[ACC_WIDTH-1:0];
   end

endmodule

`default_nettype wire

// File: rtl/redundant_accumulator.sv
//==============================================================================
// Module : redundant_accumulator
// Desc   : Resolves carry-save beats and accumulates them per packet with
//          per-beat saturation; the packet result is held until consumed.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module redundant_accumulator
   import redundant_accumulator_pkg::*;
#(
   parameter int unsigned IN_WIDTH  = DOT_OUT_WIDTH,
   parameter int unsigned ACC_WIDTH = ACC_WIDTH_DEF,
   parameter int unsigned CNT_WIDTH = CNT_WIDTH_DEF
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 in_valid_i,
   output logic                 in_ready_o,
   input  logic [IN_WIDTH-1:0]  in_sum_i,
   input  logic [IN_WIDTH-1:0]  in_carry_i,
   input  logic                 in_last_i,
   output logic                 out_valid_o,
   input  logic                 out_ready_i,
   output logic [ACC_WIDTH-1:0] out_data_o,
   output logic                 out_sat_o,
   output logic [CNT_WIDTH-1:0] out_count_o
);

   if (ACC_WIDTH < IN_WIDTH) begin : g_width_check
      $error("redundant_accumulator: ACC_WIDTH must be >= IN_WIDTH");
   end

   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   acc_state_e           r_state;
   acc_state_e           w_state_next;
   logic                 r_s1_valid;
   logic                 r_s1_last;
   logic [ACC_WIDTH-1:0] r_s1_data;
   logic [ACC_WIDTH-1:0] w_resolved;
   logic                 w_s1_consume;
   logic                 w_in_accept;

   logic [ACC_WIDTH-1:0] r_acc;
   logic                 r_sat;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [ACC_WIDTH:0]   w_sum_wide;
   logic                 w_ovf_pos;
   logic                 w_ovf_neg;
   logic [ACC_WIDTH-1:0] w_acc_next;
   logic                 w_sat_next;
   logic [CNT_WIDTH-1:0] w_cnt_next;

   logic [ACC_WIDTH-1:0] r_out_data;
   logic                 r_out_sat;
   logic [CNT_WIDTH-1:0] r_out_count;

   cs_resolve #(
      .IN_WIDTH  (IN_WIDTH),
      .ACC_WIDTH (ACC_WIDTH)
   ) u_cs_resolve (
      .sum_i   (in_sum_i),
      .carry_i (in_carry_i),
      .value_o (w_resolved)
   );

   // Ready depends only on registered state, never on in_valid_i.
   assign w_s1_consume = r_s1_valid && (r_state == ACCUM);
   assign in_ready_o   = !r_s1_valid || w_s1_consume;
   assign w_in_accept  = in_valid_i && in_ready_o;

   // One guard bit exposes signed overflow of the per-beat add.
   assign w_sum_wide = {r_acc[ACC_WIDTH-1], r_acc} + {r_s1_data[ACC_WIDTH-1], r_s1_data};
   assign w_ovf_pos  = (w_sum_wide[ACC_WIDTH:ACC_WIDTH-1] == 2'b01);
   assign w_ovf_neg  = (w_sum_wide[ACC_WIDTH:ACC_WIDTH-1] == 2'b10);
   assign w_acc_next = w_ovf_pos ? ACC_MAX :
                       w_ovf_neg ? ACC_MIN : w_sum_wide[ACC_WIDTH-1:0];
   assign w_sat_next = r_sat || w_ovf_pos || w_ovf_neg;
   assign w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + CNT_WIDTH'(1);

   always_comb begin
      w_state_next = r_state;
      out_valid_o  = 1'b0;
      case (r_state)
         ACCUM: begin
            if (w_s1_consume && r_s1_last) begin
               w_state_next = HOLD;
            end
         end
         HOLD: begin
            out_valid_o = 1'b1;
            if (out_ready_i) begin
               w_state_next = ACCUM;
            end
         end
         default: w_state_next = ACCUM;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_state    <= ACCUM;
         r_s1_valid <= 1'b0;
         r_s1_last  <= 1'b0;
         r_s1_data  <= '0;
      end else begin
         r_state <= w_state_next;
         if (w_in_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= w_resolved;
            r_s1_last  <= in_last_i;
         end else if (w_s1_consume) begin
            r_s1_valid <= 1'b0;
         end
      end
   end

   // The last beat is folded into the output registers while the running
   // totals restart for the next packet.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_acc       <= '0;
         r_sat       <= 1'b0;
         r_cnt       <= '0;
         r_out_data  <= '0;
         r_out_sat   <= 1'b0;
         r_out_count <= '0;
      end else if (w_s1_consume) begin
         if (r_s1_last) begin
            r_out_data  <= w_acc_next;
            r_out_sat   <= w_sat_next;
            r_out_count <= w_cnt_next;
            r_acc       <= '0;
            r_sat       <= 1'b0;
            r_cnt       <= '0;
         end else begin
            r_acc <= w_acc_next;
            r_sat <= w_sat_next;
            r_cnt <= w_cnt_next;
         end
      end
   end

   assign out_data_o  = r_out_data;
   assign out_sat_o   = r_out_sat;
   assign out_count_o = r_out_count;

endmodule

`default_nettype wire

// File: tb/tb_redundant_accumulator.sv
//==============================================================================
// Module : tb_redundant_accumulator
// Desc   : Self-checking bench driving a wide and a narrow accumulator with
//          the same beats, compared against a packet-level arithmetic model.
// Rev    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_redundant_accumulator;

   localparam int IW   = 20;
   localparam int AW_A = 32;
   localparam int CW_A = 16;
   localparam int AW_B = 20;
   localparam int CW_B = 3;

   logic            clk_i = 1'b0;
   logic            rst_ni;
   logic            in_valid;
   logic [IW-1:0]   in_sum;
   logic [IW-1:0]   in_carry;
   logic            in_last;
   logic            out_ready;

   logic            in_ready_a, out_valid_a, out_sat_a;
   logic [AW_A-1:0] out_data_a;
   logic [CW_A-1:0] out_count_a;
   logic            in_ready_b, out_valid_b, out_sat_b;
   logic [AW_B-1:0] out_data_b;
   logic [CW_B-1:0] out_count_b;

   always #5 clk_i = ~clk_i;

   redundant_accumulator #(.IN_WIDTH(IW), .ACC_WIDTH(AW_A), .CNT_WIDTH(CW_A)) u_dut_a (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .in_valid_i(in_valid), .in_ready_o(in_ready_a),
      .in_sum_i(in_sum), .in_carry_i(in_carry), .in_last_i(in_last),
      .out_valid_o(out_valid_a), .out_ready_i(out_ready),
      .out_data_o(out_data_a), .out_sat_o(out_sat_a), .out_count_o(out_count_a)
   );

   redundant_accumulator #(.IN_WIDTH(IW), .ACC_WIDTH(AW_B), .CNT_WIDTH(CW_B)) u_dut_b (
      .clk_i(clk_i), .rst_ni(rst_ni),
      .in_valid_i(in_valid), .in_ready_o(in_ready_b),
      .in_sum_i(in_sum), .in_carry_i(in_carry), .in_last_i(in_last),
      .out_valid_o(out_valid_b), .out_ready_i(out_ready),
      .out_data_o(out_data_b), .out_sat_o(out_sat_b), .out_count_o(out_count_b)
   );

   typedef struct {
      longint data;
      bit     sat;
      longint cnt;
   } exp_t;

   exp_t          exp_a[$];
   exp_t          exp_b[$];
   logic [IW-1:0] pk_s[$];
   logic [IW-1:0] pk_c[$];
   int            checks = 0;
   int            errors = 0;
   bit            ready_low = 1'b0;

   task automatic check(input string tag, input longint obs, input longint exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint resolve(input logic [IW-1:0] s, input logic [IW-1:0] c);
      longint v;
      v = (longint'(s) + longint'(c)) % (64'sd1 <<< IW);
      if (v >= (64'sd1 <<< (IW - 1))) v = v - (64'sd1 <<< IW);
      return v;
   endfunction

   function automatic longint clamp(input longint x, input int w, inout bit sat);
      longint hi, lo;
      hi = (64'sd1 <<< (w - 1)) - 1;
      lo = -(64'sd1 <<< (w - 1));
      if (x > hi) begin sat = 1'b1; return hi; end
      if (x < lo) begin sat = 1'b1; return lo; end
      return x;
   endfunction

   task automatic close_packet();
      exp_t   ea, eb;
      longint r;
      longint n;
      ea.data = 0; ea.sat = 1'b0;
      eb.data = 0; eb.sat = 1'b0;
      for (int i = 0; i < pk_s.size(); i++) begin
         r       = resolve(pk_s[i], pk_c[i]);
         ea.data = clamp(ea.data + r, AW_A, ea.sat);
         eb.data = clamp(eb.data + r, AW_B, eb.sat);
      end
      n      = longint'(pk_s.size());
      ea.cnt = (n > (64'sd1 <<< CW_A) - 1) ? (64'sd1 <<< CW_A) - 1 : n;
      eb.cnt = (n > (64'sd1 <<< CW_B) - 1) ? (64'sd1 <<< CW_B) - 1 : n;
      exp_a.push_back(ea);
      exp_b.push_back(eb);
      pk_s.delete();
      pk_c.delete();
   endtask

   // Evaluate the handshakes set up since the last falling edge, then step
   // one cycle and update the model with whatever the DUT accepted.
   task automatic tick(output bit accepted);
      exp_t e;
      logic [IW-1:0] s_smp, c_smp;
      logic l_smp;
      check("ready_match", longint'(in_ready_a), longint'(in_ready_b));
      accepted = in_valid && in_ready_a;
      s_smp = in_sum; c_smp = in_carry; l_smp = in_last;
      if (out_valid_a && out_ready) begin
         check("result_expected_a", longint'(exp_a.size() > 0), 1);
         if (exp_a.size() > 0) begin
            e = exp_a.pop_front();
            check("data_a", longint'($signed(out_data_a)), e.data);
            check("sat_a", longint'(out_sat_a), longint'(e.sat));
            check("count_a", longint'(out_count_a), e.cnt);
         end
      end
      if (out_valid_b && out_ready) begin
         check("result_expected_b", longint'(exp_b.size() > 0), 1);
         if (exp_b.size() > 0) begin
            e = exp_b.pop_front();
            check("data_b", longint'($signed(out_data_b)), e.data);
            check("sat_b", longint'(out_sat_b), longint'(e.sat));
            check("count_b", longint'(out_count_b), e.cnt);
         end
      end
      @(posedge clk_i);
      if (accepted) begin
         pk_s.push_back(s_smp);
         pk_c.push_back(c_smp);
         if (l_smp) close_packet();
      end
      @(negedge clk_i);
   endtask

   task automatic send_beat(input logic [IW-1:0] s, input logic [IW-1:0] c,
                            input bit last, input bit cont);
      bit acc;
      int n;
      n = 0;
      in_sum = s; in_carry = c; in_last = last;
      do begin
         in_valid  = cont || ($urandom_range(0, 3) != 0);
         out_ready = ready_low ? 1'b0 : 1'($urandom_range(0, 1));
         tick(acc);
         n++;
      end while (!acc && n < 200);
      if (!acc) check("accept_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      bit acc;
      int n;
      n = 0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      while ((exp_a.size() > 0 || exp_b.size() > 0) && n < 50) begin
         tick(acc);
         n++;
      end
      check("drain_timeout", longint'(exp_a.size() + exp_b.size()), 0);
      out_ready = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog expired: observed no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc;
      int acc_cnt;
      int n;
      rst_ni = 1'b0; in_valid = 1'b0; in_sum = '0; in_carry = '0;
      in_last = 1'b0; out_ready = 1'b0;
      repeat (2) @(negedge clk_i);
      check("rst_in_ready", longint'(in_ready_a), 1);
      check("rst_out_valid", longint'(out_valid_a), 0);
      check("rst_out_data", longint'(out_data_a), 0);
      check("rst_out_sat", longint'(out_sat_a), 0);
      check("rst_out_count", longint'(out_count_a), 0);
      rst_ni = 1'b1;
      @(negedge clk_i);

      // Single beat: result two edges after acceptance.
      ready_low = 1'b1;
      send_beat(20'h00005, 20'h00003, 1'b1, 1'b1);
      check("lat_valid_early", longint'(out_valid_a), 0);
      tick(acc);
      check("lat_valid", longint'(out_valid_a), 1);
      check("single_data", longint'($signed(out_data_a)), 8);
      check("single_count", longint'(out_count_a), 1);
      check("single_sat", longint'(out_sat_a), 0);
      ready_low = 1'b0;
      drain();

      // Negative resolved value followed by a positive one.
      ready_low = 1'b1;
      send_beat(20'hFFFFF, 20'h00000, 1'b0, 1'b1);
      send_beat(20'h00000, 20'h00002, 1'b1, 1'b1);
      tick(acc);
      check("two_data", longint'($signed(out_data_a)), 1);
      check("two_count", longint'(out_count_a), 2);
      ready_low = 1'b0;
      drain();

      // Positive overflow only in the 20-bit accumulator.
      ready_low = 1'b1;
      send_beat(20'h7FFFF, 20'h00000, 1'b0, 1'b1);
      send_beat(20'h00001, 20'h00000, 1'b1, 1'b1);
      tick(acc);
      check("satp_data_b", longint'($signed(out_data_b)), 524287);
      check("satp_sat_b", longint'(out_sat_b), 1);
      check("satp_data_a", longint'($signed(out_data_a)), 524288);
      check("satp_sat_a", longint'(out_sat_a), 0);
      ready_low = 1'b0;
      drain();

      // Output backpressure: one beat buffers, then input stalls.
      ready_low = 1'b1;
      send_beat(20'h00001, 20'h00001, 1'b0, 1'b1);
      send_beat(20'h00002, 20'h00002, 1'b1, 1'b1);
      send_beat(20'h00003, 20'h00000, 1'b0, 1'b1);
      in_sum = 20'h00004; in_carry = 20'h00000; in_last = 1'b1; in_valid = 1'b1;
      acc_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         tick(acc);
         if (acc) acc_cnt++;
      end
      check("stall_accepts", longint'(acc_cnt), 0);
      check("stall_in_ready", longint'(in_ready_a), 0);
      check("stall_out_valid", longint'(out_valid_a), 1);
      check("stall_data", longint'($signed(out_data_a)), 6);
      check("stall_count", longint'(out_count_a), 2);
      ready_low = 1'b0;
      send_beat(20'h00004, 20'h00000, 1'b1, 1'b1);
      drain();

      // Randomized packets with random gaps and backpressure.
      for (int p = 0; p < 30; p++) begin
         n = $urandom_range(1, 10);
         for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 2) == 0)
               send_beat(20'($urandom_range(0, 255)), 20'($urandom_range(0, 255)), i == n - 1, 1'b0);
            else
               send_beat(20'($urandom), 20'($urandom), i == n - 1, 1'b0);
         end
      end
      drain();

      // Reset part-way through a packet discards it.
      for (int i = 0; i < 3; i++) send_beat(20'h00011, 20'h00001, 1'b0, 1'b1);
      #2 rst_ni = 1'b0;
      #1;
      check("midrst_out_valid", longint'(out_valid_a), 0);
      check("midrst_in_ready", longint'(in_ready_a), 1);
      check("midrst_out_data", longint'(out_data_a), 0);
      pk_s.delete(); pk_c.delete(); exp_a.delete(); exp_b.delete();
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      ready_low = 1'b1;
      send_beat(20'h00005, 20'h00003, 1'b1, 1'b1);
      tick(acc);
      check("post_rst_data", longint'($signed(out_data_a)), 8);
      check("post_rst_count", longint'(out_count_a), 1);
      ready_low = 1'b0;
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
